// File: rtl/mem_access_ctrl.sv
// MEM-stage data-bus controller: decodes the EX/MEM instruction, runs one req/ack bus transaction per load/store,
// steers store byte lanes and extends load data. Optional MEM_ALIGN_EXC_EN raises AdEL/AdES instead of misaligned accesses.
module mem_access_ctrl #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   em_ir,
  input  logic [31:0]   em_alu,
  input  logic [31:0]   em_wdata,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_be,
  output logic [31:0]   bus_wdata,
  input  logic          bus_ack,
  input  logic [31:0]   bus_rdata,
  output logic          stall,
  output logic          ld_valid,
  output logic [31:0]   ld_data,
  output logic          exc_valid,
  output logic [4:0]    exc_code,
  output logic [31:0]   exc_badvaddr,
  output logic [1:0]    dbg_state
);

  // Bus handshake: bus_req rises the cycle after a memory op is seen and stays high, with
  // addr/we/be/wdata stable, until the cycle bus_ack is sampled high; that edge completes the
  // transfer and bus_rdata is captured. bus_ack outside a pending request is ignored.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]    bus_be_q, bus_be_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic          ld_valid_q, ld_valid_d;
  logic [31:0]   ld_data_q, ld_data_d;
  logic          exc_valid_q, exc_valid_d;
  logic [4:0]    exc_code_q, exc_code_d;
  logic [31:0]   exc_badvaddr_q, exc_badvaddr_d;
  logic [1:0]    off_q, off_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic          is_ld_q, is_ld_d;

  logic [5:0]  opcode;
  logic        is_ld, is_st, uns, mem_op, exc_hit;
  logic [1:0]  size;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic        unused_ok;

  assign opcode    = em_ir[31:26];
  assign unused_ok = ^{em_ir[25:0]};

  // size: 0 = byte, 1 = half, 2 = word
  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    size  = 2'd0;
    uns   = 1'b0;
    case (opcode)
      6'b100000: begin is_ld = 1'b1; size = 2'd0; end
      6'b100001: begin is_ld = 1'b1; size = 2'd1; end
      6'b100011: begin is_ld = 1'b1; size = 2'd2; end
      6'b100100: begin is_ld = 1'b1; size = 2'd0; uns = 1'b1; end
      6'b100101: begin is_ld = 1'b1; size = 2'd1; uns = 1'b1; end
      6'b101000: begin is_st = 1'b1; size = 2'd0; end
      6'b101001: begin is_st = 1'b1; size = 2'd1; end
      6'b101011: begin is_st = 1'b1; size = 2'd2; end
      default: ;
    endcase
  end

  assign mem_op = is_ld | is_st;

`ifdef MEM_ALIGN_EXC_EN
  logic misalign;
  assign misalign = ((size == 2'd2) && (em_alu[1:0] != 2'b00)) ||
                    ((size == 2'd1) && em_alu[0]);
  assign exc_hit  = mem_op & misalign;
`else
  assign exc_hit  = 1'b0;
`endif

  assign stall = ((state_q == IDLE) && mem_op && !exc_hit) || (state_q == BUSY);

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = em_wdata;
    case (size)
      2'd0: begin
        st_be    = 4'b0001 << em_alu[1:0];
        st_wdata = {4{em_wdata[7:0]}};
      end
      2'd1: begin
        st_be    = em_alu[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{em_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = bus_rdata[7:0];
    case (off_q)
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      2'd3:    ld_byte = bus_rdata[31:24];
      default: ld_byte = bus_rdata[7:0];
    endcase
    ld_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_q)
      2'd0:    ld_ext = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'd1:    ld_ext = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    bus_req_d      = bus_req_q;
    bus_we_d       = bus_we_q;
    bus_addr_d     = bus_addr_q;
    bus_be_d       = bus_be_q;
    bus_wdata_d    = bus_wdata_q;
    ld_valid_d     = 1'b0;
    ld_data_d      = ld_data_q;
    exc_valid_d    = 1'b0;
    exc_code_d     = exc_code_q;
    exc_badvaddr_d = exc_badvaddr_q;
    off_d          = off_q;
    size_d         = size_q;
    uns_d          = uns_q;
    is_ld_d        = is_ld_q;
    case (state_q)
      IDLE: begin
        if (exc_hit) begin
          exc_valid_d    = 1'b1;
          exc_code_d     = is_st ? 5'd5 : 5'd4;
          exc_badvaddr_d = em_alu;
        end else if (mem_op) begin
          state_d     = BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = is_st;
          bus_addr_d  = {em_alu[AW-1:2], 2'b00};
          bus_be_d    = is_st ? st_be : 4'b1111;
          bus_wdata_d = is_st ? st_wdata : 32'h0;
          off_d       = em_alu[1:0];
          size_d      = size;
          uns_d       = uns;
          is_ld_d     = is_ld;
        end
      end
      BUSY: begin
        if (bus_ack) begin
          state_d   = DONE;
          bus_req_d = 1'b0;
          if (is_ld_q) begin
            ld_valid_d = 1'b1;
            ld_data_d  = ld_ext;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      bus_req_q      <= 1'b0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= '0;
      bus_be_q       <= 4'h0;
      bus_wdata_q    <= 32'h0;
      ld_valid_q     <= 1'b0;
      ld_data_q      <= 32'h0;
      exc_valid_q    <= 1'b0;
      exc_code_q     <= 5'd0;
      exc_badvaddr_q <= 32'h0;
      off_q          <= 2'd0;
      size_q         <= 2'd0;
      uns_q          <= 1'b0;
      is_ld_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      bus_req_q      <= bus_req_d;
      bus_we_q       <= bus_we_d;
      bus_addr_q     <= bus_addr_d;
      bus_be_q       <= bus_be_d;
      bus_wdata_q    <= bus_wdata_d;
      ld_valid_q     <= ld_valid_d;
      ld_data_q      <= ld_data_d;
      exc_valid_q    <= exc_valid_d;
      exc_code_q     <= exc_code_d;
      exc_badvaddr_q <= exc_badvaddr_d;
      off_q          <= off_d;
      size_q         <= size_d;
      uns_q          <= uns_d;
      is_ld_q        <= is_ld_d;
    end
  end

  assign bus_req      = bus_req_q;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_be       = bus_be_q;
  assign bus_wdata    = bus_wdata_q;
  assign ld_valid     = ld_valid_q;
  assign ld_data      = ld_data_q;
  assign exc_valid    = exc_valid_q;
  assign exc_code     = exc_code_q;
  assign exc_badvaddr = exc_badvaddr_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: hand-computed loads, stores, non-memory ops, stray acks and mid-transfer reset.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] em_ir, em_alu, em_wdata;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata, bus_rdata;
  logic        stall, ld_valid, exc_valid;
  logic [31:0] ld_data, exc_badvaddr;
  logic [4:0]  exc_code;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] IR_LB  = {6'b100000, 26'h0};
  localparam logic [31:0] IR_LH  = {6'b100001, 26'h0};
  localparam logic [31:0] IR_LW  = {6'b100011, 26'h0};
  localparam logic [31:0] IR_LBU = {6'b100100, 26'h0};
  localparam logic [31:0] IR_LHU = {6'b100101, 26'h0};
  localparam logic [31:0] IR_SB  = {6'b101000, 26'h0};
  localparam logic [31:0] IR_SH  = {6'b101001, 26'h0};
  localparam logic [31:0] IR_SW  = {6'b101011, 26'h0};
  localparam logic [31:0] IR_ADD = 32'h0000_0020;

  mem_access_ctrl #(.AW(32)) dut (
    .clk(clk), .reset(reset), .em_ir(em_ir), .em_alu(em_alu), .em_wdata(em_wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stall(stall),
    .ld_valid(ld_valid), .ld_data(ld_data), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_badvaddr(exc_badvaddr), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Results of the last run_op call
  int          r_stall, r_req, r_ldv, r_exc;
  logic        r_retired, r_we;
  logic [31:0] r_addr, r_wd, r_ldd, r_bad;
  logic [3:0]  r_be;
  logic [4:0]  r_code;

  // Presents one instruction, acks in the ack_n-th bus_req cycle, advances EX/MEM when stall drops.
  task automatic run_op(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [31:0] rd, input int ack_n);
    int reqc;
    logic acked, retire_now;
    r_stall = 0; r_req = 0; r_ldv = 0; r_exc = 0; r_retired = 1'b0;
    r_we = 1'b0; r_addr = '0; r_wd = '0; r_ldd = '0; r_be = '0; r_bad = '0; r_code = '0;
    reqc = 0; acked = 1'b0;
    em_ir = ir; em_alu = alu; em_wdata = wd;
    for (int i = 0; i < 14; i++) begin
      #1;
      retire_now = 1'b0;
      if (stall) r_stall++;
      if (bus_req) begin
        if (reqc == 0) begin
          r_addr = bus_addr; r_be = bus_be; r_wd = bus_wdata; r_we = bus_we;
        end
        reqc++;
        r_req++;
      end
      if (ld_valid) begin r_ldv++; r_ldd = ld_data; end
      if (exc_valid) begin r_exc++; r_code = exc_code; r_bad = exc_badvaddr; end
      if (!stall && !r_retired) begin r_retired = 1'b1; retire_now = 1'b1; end
      bus_ack   = bus_req && !acked && (reqc == ack_n);
      bus_rdata = bus_ack ? rd : 32'h0;
      if (bus_ack) acked = 1'b1;
      next_cycle();
      bus_ack = 1'b0;
      if (retire_now) em_ir = IR_ADD;
    end
  endtask

  initial begin
    reset = 1'b1; em_ir = IR_ADD; em_alu = 0; em_wdata = 0; bus_ack = 0; bus_rdata = 0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    #1;
    chk("rst_req", {31'h0, bus_req}, 32'd0);
    chk("rst_stall", {31'h0, stall}, 32'd0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_be", {28'h0, bus_be}, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_ld_data", ld_data, 32'h0);
    chk("rst_ld_valid", {31'h0, ld_valid}, 32'd0);
    chk("rst_exc_valid", {31'h0, exc_valid}, 32'd0);
    chk("rst_state", {30'h0, dbg_state}, 32'd0);
    next_cycle();

    // lw, ack in third req cycle: stall covers op cycle + 3 busy cycles
    run_op(IR_LW, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 3);
    chk("lw_retired", {31'h0, r_retired}, 32'd1);
    chk("lw_stall", r_stall, 32'd4);
    chk("lw_req_cycles", r_req, 32'd3);
    chk("lw_addr", r_addr, 32'h0000_1004);
    chk("lw_be", {28'h0, r_be}, 32'hF);
    chk("lw_we", {31'h0, r_we}, 32'd0);
    chk("lw_ldv", r_ldv, 32'd1);
    chk("lw_data", r_ldd, 32'hDEAD_BEEF);

    run_op(IR_SB, 32'h0000_2002, 32'h1234_5678, 32'h0, 1);
    chk("sb_be", {28'h0, r_be}, 32'h4);
    chk("sb_wdata", r_wd, 32'h7878_7878);
    chk("sb_we", {31'h0, r_we}, 32'd1);
    chk("sb_addr", r_addr, 32'h0000_2000);
    chk("sb_stall", r_stall, 32'd2);
    chk("sb_no_ldv", r_ldv, 32'd0);
    chk("ld_data_held", ld_data, 32'hDEAD_BEEF);

    run_op(IR_SH, 32'h0000_3002, 32'hAAAA_5555, 32'h0, 2);
    chk("sh_be", {28'h0, r_be}, 32'hC);
    chk("sh_wdata", r_wd, 32'h5555_5555);
    chk("sh_stall", r_stall, 32'd3);
    run_op(IR_SH, 32'h0000_3000, 32'h0000_BEEF, 32'h0, 1);
    chk("sh_lo_be", {28'h0, r_be}, 32'h3);
    run_op(IR_SW, 32'h0000_4000, 32'hCAFE_F00D, 32'h0, 1);
    chk("sw_be", {28'h0, r_be}, 32'hF);
    chk("sw_wdata", r_wd, 32'hCAFE_F00D);

    run_op(IR_LB, 32'h0000_5001, 32'h0, 32'h0000_80FF, 1);
    chk("lb_data", r_ldd, 32'hFFFF_FF80);
    chk("lb_stall", r_stall, 32'd2);
    run_op(IR_LBU, 32'h0000_5001, 32'h0, 32'h0000_80FF, 1);
    chk("lbu_data", r_ldd, 32'h0000_0080);
    run_op(IR_LHU, 32'h0000_5002, 32'h0, 32'hABCD_0000, 2);
    chk("lhu_data", r_ldd, 32'h0000_ABCD);
    run_op(IR_LH, 32'h0000_5002, 32'h0, 32'h8001_1234, 1);
    chk("lh_data", r_ldd, 32'hFFFF_8001);
    run_op(IR_LB, 32'h0000_5003, 32'h0, 32'h7F00_0000, 1);
    chk("lb_off3_data", r_ldd, 32'h0000_007F);
    chk("lb_off3_ldv", r_ldv, 32'd1);

    // Non-memory opcode with a stray ack: nothing happens
    em_ir = IR_ADD; em_alu = 32'h0000_1000;
    for (int i = 0; i < 4; i++) begin
      bus_ack = (i == 1);
      #1;
      chk("add_req", {31'h0, bus_req}, 32'd0);
      chk("add_stall", {31'h0, stall}, 32'd0);
      next_cycle();
      bus_ack = 1'b0;
      chk("add_ldv", {31'h0, ld_valid}, 32'd0);
    end

`ifdef MEM_ALIGN_EXC_EN
    run_op(IR_LW, 32'h0000_1002, 32'h0, 32'h0, 1);
    chk("exc_lw_cnt", r_exc, 32'd1);
    chk("exc_lw_code", {27'h0, r_code}, 32'd4);
    chk("exc_lw_bad", r_bad, 32'h0000_1002);
    chk("exc_lw_req", r_req, 32'd0);
    chk("exc_lw_stall", r_stall, 32'd0);
    run_op(IR_SH, 32'h0000_2001, 32'h0, 32'h0, 1);
    chk("exc_sh_code", {27'h0, r_code}, 32'd5);
    chk("exc_sh_req", r_req, 32'd0);
`else
    run_op(IR_LW, 32'h0000_1002, 32'h0, 32'h1111_2222, 1);
    chk("mis_lw_exc", r_exc, 32'd0);
    chk("mis_lw_addr", r_addr, 32'h0000_1000);
    chk("mis_lw_data", r_ldd, 32'h1111_2222);
`endif

    // Reset in the middle of a transfer, ack arriving right after
    em_ir = IR_LW; em_alu = 32'h0000_6000;
    next_cycle();
    chk("mid_busy_req", {31'h0, bus_req}, 32'd1);
    reset = 1'b1; em_ir = IR_ADD;
    next_cycle();
    reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h5A5A_5A5A;
    #1;
    chk("rst_mid_req", {31'h0, bus_req}, 32'd0);
    chk("rst_mid_stall", {31'h0, stall}, 32'd0);
    chk("rst_mid_state", {30'h0, dbg_state}, 32'd0);
    next_cycle();
    bus_ack = 1'b0;
    r_ldv = 0;
    for (int i = 0; i < 3; i++) begin
      if (ld_valid) r_ldv++;
      next_cycle();
    end
    chk("rst_mid_ldv", r_ldv, 32'd0);
    chk("rst_mid_ld_data", ld_data, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
